histogram_esitleme_denetleyici: RTL and testbench
=================================================

// Module: histogram_esitleme_denetleyici
// PURPOSE
//  Sequences the histogram equalization pass that follows histogram collection. On basla_i it walks
//  bins 0..255 of the histogram RAM read port and accumulates the CDF. For each bin it computes
//  lut = round((cdf-cdf_min)*255/(N-cdf_min)) with a shared sequential divider, then writes the
//  result to the equalization LUT. Sits between histogram_birimi (hazir_o/valid_o/cdf_min_o) and the pixel remap stage.
// PARAMETERS
//  PIXEL_SAYISI  76800  pixels per frame (N); 320x240
//  SAYAC_BIT     17     histogram count / CDF width
//  BOLUM_BIT     25     numerator width; >= SAYAC_BIT+8
// PORTS
//  clk_i       in   1    single clock, all logic on posedge
//  rst_i       in   1    synchronous, active-high reset
//  basla_i     in   1    start pulse; sampled only in BOSTA
//  valid_i     in   256  per-bin "RAM holds a count" bitmap; captured at start
//  cdf_min_i   in   17   count of the darkest present pixel; captured at start
//  rd_en_o     out  1    histogram RAM read strobe, active-high
//  addr_r_o    out  8    histogram RAM read address
//  data_out_i  in   17   RAM read data, valid exactly 1 cycle after rd_en_o
//  lut_wr_en_o out  1    LUT write strobe, 1-cycle pulse
//  lut_addr_o  out  8    LUT address (= bin index)
//  lut_data_o  out  8    equalized pixel value
//  mesgul_o    out  1    high from accepted start until bitti_o
//  bitti_o     out  1    1-cycle completion pulse
//  hata_o      out  1    final CDF != PIXEL_SAYISI or CDF overflow; held until next accepted start
// BEHAVIOUR
//  Reset: all outputs 0, FSM=BOSTA, bin=0, cdf=0. A reset mid-run aborts the pass at once; no further LUT writes.
//  FSM: BOSTA -(basla_i)-> OKU -> AL -> BOL -> YAZ -> (bin==255 ? SON : OKU); SON -> BOSTA.
//  BOSTA: capture valid_i and cdf_min_i; clear cdf, bin and hata. basla_i in any other state is ignored.
//  OKU: rd_en_o=1 and addr_r_o=bin only if valid[bin]; otherwise no read is issued.
//  AL: cnt = valid[bin] ? data_out_i : 0. Unwritten bins never use stale RAM data.
//    cdf_n = cdf + cnt. An overflow past 17 bits sets hata and saturates cdf.
//    Divider is started with num=(cdf_n-cdf_min)*255 + den/2 and den=N-cdf_min.
//    If cdf_n < cdf_min, num is forced to 0.
//  BOL: exactly BOLUM_BIT cycles; leaves on divider done.
//  YAZ: lut_wr_en_o=1, lut_addr_o=bin.
//    lut_data_o = den==0 ? bin : min(quotient,255).
//    bin increments; 8-bit wrap is not reached because SON is taken at 255.
//  Per-bin latency = BOLUM_BIT+3 cycles.
//  Defaults: basla_i sampled at cycle 0 -> bitti_o at cycle 1+256*28 = 7169.
//  SON: bitti_o=1; hata set if cdf != PIXEL_SAYISI. mesgul_o falls in the same cycle.
//  Exactly one LUT write per bin, in ascending order; rd_en_o and lut_wr_en_o are never high together.
//  All arithmetic is unsigned; den is 17 bits; quotient is BOLUM_BIT bits truncated after clamp.
// STRUCTURE
//  sabitler.vh gains: PIXEL_SAYISI, HIST_SAYAC_BIT (17), LUT_BIT (8). FSM state encodings stay local.
//  One sub-module: sirali_bolucu (restoring divider, params BOLUM_BIT).
//    Interface: basla/bolunen/bolen in; bolum/bitti out.
//    Divide-by-0 returns all ones; the controller bypasses it via the den==0 rule.
// TESTING
//  1 uniform: every bin valid, count 300, cdf_min=300 -> lut[k]=k for all k; hata_o=0; bitti_o at cycle 7169.
//  2 two-level: bins 10 and 200 each 38400, only those valid, cdf_min=38400 -> lut[0..199]=0, lut[200..255]=255.
//  3 flat image: bin 77=76800 only, cdf_min=76800 -> den=0, lut[k]=k; hata_o=0.
//  4 valid gating: bins 0 and 255 valid (38400 each), RAM elsewhere preloaded 999
//    -> exactly 2 rd_en_o pulses; lut[1..254]=0, lut[255]=255.
//  5 count mismatch: counts summing to 76799 -> hata_o=1 with bitti_o; cleared by next basla_i.
//  6 control: basla_i during run ignored; rst_i at bin 100 -> no more lut writes, mesgul_o=0;
//    new basla_i restarts at bin 0.

Source files
------------

// File: rtl/histogram_esitleme_denetleyici_pkg.sv
// rtl/histogram_esitleme_denetleyici_pkg.sv - shared constants for the histogram equalization controller
package histogram_esitleme_denetleyici_pkg;

    // Pixels in one 320x240 frame.
    localparam int FRAME_PIXEL_SAYISI = 76800;

    // Width of one histogram bin count and of the running CDF.
    localparam int HIST_SAYAC_BIT = 17;

    // Width of one equalized pixel value held in the LUT.
    localparam int LUT_BIT = 8;

    // Number of histogram bins (one per 8-bit gray level).
    localparam int BIN_SAYISI = 256;

    // Default divider width; must cover a full CDF scaled by 255.
    localparam int BOLUM_BIT_VARSAYILAN = 25;

endpackage

// File: rtl/sirali_bolucu.sv
// rtl/sirali_bolucu.sv - restoring sequential divider, one quotient bit per cycle
module sirali_bolucu
    import histogram_esitleme_denetleyici_pkg::*;
#(
    parameter int BOLUM_BIT = BOLUM_BIT_VARSAYILAN
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 basla_i,
    input  logic [BOLUM_BIT-1:0] bolunen_i,
    input  logic [BOLUM_BIT-1:0] bolen_i,
    output logic [BOLUM_BIT-1:0] bolum_o,
    output logic                 bitti_o
);

    localparam int ADIM_BIT = $clog2(BOLUM_BIT + 1);

    logic [BOLUM_BIT-1:0] r_kalan;
    logic [BOLUM_BIT-1:0] r_bolum;
    logic [BOLUM_BIT-1:0] r_bolen;
    logic [ADIM_BIT-1:0]  r_adim;
    logic                 r_bitti;

    logic [BOLUM_BIT-1:0] w_kalan_gir;
    logic [BOLUM_BIT-1:0] w_bolum_gir;
    logic [BOLUM_BIT-1:0] w_bolen;
    logic [BOLUM_BIT:0]   w_kaydir;
    logic                 w_cikar;
    logic [BOLUM_BIT-1:0] w_kalan_cik;
    logic [BOLUM_BIT-1:0] w_bolum_cik;

    // One restoring step; the start cycle already performs the first step on the fresh operands
    always_comb begin
        w_kalan_gir = basla_i ? '0 : r_kalan;
        w_bolum_gir = basla_i ? bolunen_i : r_bolum;
        w_bolen     = basla_i ? bolen_i : r_bolen;
        w_kaydir    = {w_kalan_gir, w_bolum_gir[BOLUM_BIT-1]};
        w_cikar     = (w_kaydir >= {1'b0, w_bolen});
        w_kalan_cik = w_cikar ? BOLUM_BIT'(w_kaydir - {1'b0, w_bolen})
                              : w_kaydir[BOLUM_BIT-1:0];
        w_bolum_cik = {w_bolum_gir[BOLUM_BIT-2:0], w_cikar};
    end

    // Load on start, then run the remaining BOLUM_BIT-1 steps and flag the last one
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_kalan <= '0;
            r_bolum <= '0;
            r_bolen <= '0;
            r_adim  <= '0;
            r_bitti <= 1'b0;
        end else begin
            r_bitti <= 1'b0;
            if (basla_i) begin
                r_kalan <= w_kalan_cik;
                r_bolum <= w_bolum_cik;
                r_bolen <= bolen_i;
                r_adim  <= ADIM_BIT'(BOLUM_BIT - 1);
            end else if (r_adim != '0) begin
                r_kalan <= w_kalan_cik;
                r_bolum <= w_bolum_cik;
                r_adim  <= r_adim - 1'b1;
                if (r_adim == ADIM_BIT'(1)) begin
                    r_bitti <= 1'b1;
                end
            end
        end
    end

    assign bolum_o = r_bolum;
    assign bitti_o = r_bitti;

endmodule

// File: rtl/histogram_esitleme_denetleyici.sv
// rtl/histogram_esitleme_denetleyici.sv - walks the histogram, builds the CDF and writes the equalization LUT
module histogram_esitleme_denetleyici
    import histogram_esitleme_denetleyici_pkg::*;
#(
    parameter int PIXEL_SAYISI = FRAME_PIXEL_SAYISI,
    parameter int SAYAC_BIT    = HIST_SAYAC_BIT,
    parameter int BOLUM_BIT    = BOLUM_BIT_VARSAYILAN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  basla_i,
    input  logic [BIN_SAYISI-1:0] valid_i,
    input  logic [SAYAC_BIT-1:0]  cdf_min_i,
    output logic                  rd_en_o,
    output logic [7:0]            addr_r_o,
    input  logic [SAYAC_BIT-1:0]  data_out_i,
    output logic                  lut_wr_en_o,
    output logic [7:0]            lut_addr_o,
    output logic [LUT_BIT-1:0]    lut_data_o,
    output logic                  mesgul_o,
    output logic                  bitti_o,
    output logic                  hata_o
);

    localparam int LUT_MAX = (1 << LUT_BIT) - 1;

    typedef enum logic [2:0] {
        BOSTA = 3'd0,
        OKU   = 3'd1,
        AL    = 3'd2,
        BOL   = 3'd3,
        YAZ   = 3'd4,
        SON   = 3'd5
    } durum_t;

    durum_t                r_durum;
    logic [BIN_SAYISI-1:0] r_valid;
    logic [SAYAC_BIT-1:0]  r_cdf_min;
    logic [SAYAC_BIT-1:0]  r_cdf;
    logic [7:0]            r_bin;
    logic                  r_rd_en;
    logic [7:0]            r_addr;
    logic                  r_lut_wr_en;
    logic [7:0]            r_lut_addr;
    logic [LUT_BIT-1:0]    r_lut_data;
    logic                  r_mesgul;
    logic                  r_bitti;
    logic                  r_hata;

    logic [SAYAC_BIT-1:0]  w_cnt;
    logic [SAYAC_BIT:0]    w_toplam;
    logic                  w_tasma;
    logic [SAYAC_BIT-1:0]  w_cdf_n;
    logic [SAYAC_BIT-1:0]  w_den;
    logic [BOLUM_BIT-1:0]  w_num;
    logic [7:0]            w_sonraki_bin;
    logic                  w_bol_basla;
    logic [BOLUM_BIT-1:0]  w_bolum;
    logic                  w_bol_bitti;
    logic [LUT_BIT-1:0]    w_lut_deger;

    // CDF update and divider operands; a bin without a RAM entry contributes nothing
    always_comb begin
        w_cnt         = r_valid[r_bin] ? data_out_i : '0;
        w_toplam      = {1'b0, r_cdf} + {1'b0, w_cnt};
        w_tasma       = w_toplam[SAYAC_BIT];
        w_cdf_n       = w_tasma ? '1 : w_toplam[SAYAC_BIT-1:0];
        w_den         = SAYAC_BIT'(PIXEL_SAYISI) - r_cdf_min;
        if (w_cdf_n < r_cdf_min) begin
            w_num = '0;
        end else begin
            w_num = BOLUM_BIT'(w_cdf_n - r_cdf_min) * BOLUM_BIT'(255)
                  + BOLUM_BIT'(w_den >> 1);
        end
        w_sonraki_bin = r_bin + 8'd1;
        w_bol_basla   = (r_durum == AL);
        // A flat image (den==0) maps every level onto itself
        if (w_den == '0) begin
            w_lut_deger = r_bin;
        end else if (w_bolum > BOLUM_BIT'(LUT_MAX)) begin
            w_lut_deger = LUT_BIT'(LUT_MAX);
        end else begin
            w_lut_deger = w_bolum[LUT_BIT-1:0];
        end
    end

    sirali_bolucu #(
        .BOLUM_BIT (BOLUM_BIT)
    ) u_bolucu (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .basla_i   (w_bol_basla),
        .bolunen_i (w_num),
        .bolen_i   (BOLUM_BIT'(w_den)),
        .bolum_o   (w_bolum),
        .bitti_o   (w_bol_bitti)
    );

    // Pass sequencer; every output is registered and set on the transition into its state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum     <= BOSTA;
            r_valid     <= '0;
            r_cdf_min   <= '0;
            r_cdf       <= '0;
            r_bin       <= '0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_lut_wr_en <= 1'b0;
            r_lut_addr  <= '0;
            r_lut_data  <= '0;
            r_mesgul    <= 1'b0;
            r_bitti     <= 1'b0;
            r_hata      <= 1'b0;
        end else begin
            r_rd_en     <= 1'b0;
            r_lut_wr_en <= 1'b0;
            r_bitti     <= 1'b0;
            case (r_durum)
                BOSTA: begin
                    if (basla_i) begin
                        r_valid   <= valid_i;
                        r_cdf_min <= cdf_min_i;
                        r_cdf     <= '0;
                        r_bin     <= '0;
                        r_hata    <= 1'b0;
                        r_mesgul  <= 1'b1;
                        r_rd_en   <= valid_i[0];
                        if (valid_i[0]) begin
                            r_addr <= '0;
                        end
                        r_durum   <= OKU;
                    end
                end
                OKU: begin
                    r_durum <= AL;
                end
                AL: begin
                    r_cdf <= w_cdf_n;
                    if (w_tasma) begin
                        r_hata <= 1'b1;
                    end
                    r_durum <= BOL;
                end
                BOL: begin
                    if (w_bol_bitti) begin
                        r_lut_wr_en <= 1'b1;
                        r_lut_addr  <= r_bin;
                        r_lut_data  <= w_lut_deger;
                        r_durum     <= YAZ;
                    end
                end
                YAZ: begin
                    if (r_bin == 8'd255) begin
                        r_durum <= SON;
                    end else begin
                        r_bin   <= w_sonraki_bin;
                        r_rd_en <= r_valid[w_sonraki_bin];
                        if (r_valid[w_sonraki_bin]) begin
                            r_addr <= w_sonraki_bin;
                        end
                        r_durum <= OKU;
                    end
                end
                SON: begin
                    r_bitti  <= 1'b1;
                    r_mesgul <= 1'b0;
                    if (r_cdf != SAYAC_BIT'(PIXEL_SAYISI)) begin
                        r_hata <= 1'b1;
                    end
                    r_durum  <= BOSTA;
                end
                default: begin
                    r_durum <= BOSTA;
                end
            endcase
        end
    end

    assign rd_en_o     = r_rd_en;
    assign addr_r_o    = r_addr;
    assign lut_wr_en_o = r_lut_wr_en;
    assign lut_addr_o  = r_lut_addr;
    assign lut_data_o  = r_lut_data;
    assign mesgul_o    = r_mesgul;
    assign bitti_o     = r_bitti;
    assign hata_o      = r_hata;

endmodule

// File: tb/tb_histogram_esitleme_denetleyici.sv
// tb/tb_histogram_esitleme_denetleyici.sv - self-checking bench for the histogram equalization controller
module tb_histogram_esitleme_denetleyici;

    localparam int N       = 76800;
    localparam int SAT     = 131071;
    localparam int LATENCY = 7169;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         basla_i;
    logic [255:0] valid_i;
    logic [16:0]  cdf_min_i;
    logic [16:0]  data_out_i;
    logic         rd_en_o;
    logic [7:0]   addr_r_o;
    logic         lut_wr_en_o;
    logic [7:0]   lut_addr_o;
    logic [7:0]   lut_data_o;
    logic         mesgul_o;
    logic         bitti_o;
    logic         hata_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [16:0] ram [256];
    int  lut_obs [256];
    int  exp_lut [256];
    bit  exp_hata;
    int  ilk_fark;

    int  n_wr, n_rd, n_mesgul, next_addr, order_err, overlap, bitti_cyc;
    bit  got_bitti, hata_at_bitti, mesgul_at_bitti, hata_after_start, mesgul_after_start;

    histogram_esitleme_denetleyici dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .basla_i     (basla_i),
        .valid_i     (valid_i),
        .cdf_min_i   (cdf_min_i),
        .rd_en_o     (rd_en_o),
        .addr_r_o    (addr_r_o),
        .data_out_i  (data_out_i),
        .lut_wr_en_o (lut_wr_en_o),
        .lut_addr_o  (lut_addr_o),
        .lut_data_o  (lut_data_o),
        .mesgul_o    (mesgul_o),
        .bitti_o     (bitti_o),
        .hata_o      (hata_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Histogram RAM: one-cycle read latency, junk on the bus when no read is issued
    always @(posedge clk_i) data_out_i <= rd_en_o ? ram[addr_r_o] : 17'($urandom);

    always @(negedge clk_i) begin
        if (rd_en_o) n_rd++;
        if (mesgul_o) n_mesgul++;
        if (rd_en_o && lut_wr_en_o) overlap++;
        if (lut_wr_en_o) begin
            if (int'(lut_addr_o) != next_addr) order_err++;
            lut_obs[lut_addr_o] = int'(lut_data_o);
            next_addr = int'(lut_addr_o) + 1;
            n_wr++;
        end
        if (bitti_o) begin
            got_bitti       = 1'b1;
            bitti_cyc       = cyc;
            hata_at_bitti   = hata_o;
            mesgul_at_bitti = mesgul_o;
        end
    end

    task automatic clear_mon();
        n_wr = 0; n_rd = 0; n_mesgul = 0; next_addr = 0; order_err = 0; overlap = 0;
        got_bitti = 1'b0; bitti_cyc = 0;
        for (int k = 0; k < 256; k++) lut_obs[k] = -1;
    endtask

    function automatic int lut_fark();
        int bad = 0;
        ilk_fark = 0;
        for (int k = 255; k >= 0; k--) begin
            if (lut_obs[k] != exp_lut[k]) begin
                bad++;
                ilk_fark = k;
            end
        end
        return bad;
    endfunction

    // Reference: running CDF and rounded scaling done in plain integer arithmetic
    task automatic model(input logic [255:0] v, input int cmin);
        int cdf = 0;
        int den = N - cmin;
        int q;
        exp_hata = 1'b0;
        for (int k = 0; k < 256; k++) begin
            cdf += v[k] ? int'(ram[k]) : 0;
            if (cdf > SAT) begin
                cdf = SAT;
                exp_hata = 1'b1;
            end
            if (den == 0) exp_lut[k] = k;
            else if (cdf < cmin) exp_lut[k] = 0;
            else begin
                q = ((cdf - cmin) * 255 + den / 2) / den;
                exp_lut[k] = (q > 255) ? 255 : q;
            end
        end
        if (cdf != N) exp_hata = 1'b1;
    endtask

    // Random image: valid bins get a random share of 'total', others hold junk
    task automatic make_image(input int total, output logic [255:0] v, output logic [16:0] cmin);
        int rem = total;
        int nleft = 0;
        int cnt;
        bit found = 1'b0;
        for (int k = 0; k < 256; k++) v[k] = ($urandom_range(0, 3) != 0);
        v[$urandom_range(0, 255)] = 1'b1;
        for (int k = 0; k < 256; k++) if (v[k]) nleft++;
        cmin = '0;
        for (int k = 0; k < 256; k++) begin
            if (v[k]) begin
                cnt = (nleft == 1) ? rem : int'($urandom_range(0, (2 * rem) / nleft));
                rem -= cnt;
                nleft--;
                ram[k] = 17'(cnt);
                if (!found && cnt != 0) begin
                    cmin = 17'(cnt);
                    found = 1'b1;
                end
            end else begin
                ram[k] = 17'($urandom_range(1000, 60000));
            end
        end
    endtask

    task automatic run_pass(input logic [255:0] v, input logic [16:0] cmin, input int poke, output int lat);
        int s;
        int n = 0;
        clear_mon();
        @(negedge clk_i);
        valid_i = v; cdf_min_i = cmin; basla_i = 1'b1; s = cyc;
        @(negedge clk_i);
        basla_i = 1'b0;
        hata_after_start = hata_o;
        mesgul_after_start = mesgul_o;
        while (!got_bitti && n < 8000) begin
            @(negedge clk_i);
            n++;
            basla_i = (n == poke);
        end
        basla_i = 1'b0;
        lat = got_bitti ? (bitti_cyc - (s + 1)) : -1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; basla_i = 1'b0; valid_i = '0; cdf_min_i = '0;
        for (int k = 0; k < 256; k++) ram[k] = '0;
        repeat (3) @(negedge clk_i);
        n_tests++;
        if ({rd_en_o, addr_r_o, lut_wr_en_o, lut_addr_o, lut_data_o, mesgul_o, bitti_o, hata_o} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {rd_en_o, addr_r_o, lut_wr_en_o, lut_addr_o, lut_data_o, mesgul_o, bitti_o, hata_o});
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_uniform();
        int lat, bad;
        for (int k = 0; k < 256; k++) begin
            ram[k] = 17'd300;
            exp_lut[k] = k;
        end
        run_pass('1, 17'd300, -1, lat);
        n_tests++;
        if (lat !== LATENCY) begin
            n_fail++; $display("FAIL uniform_latency: got %0d expected %0d", lat, LATENCY);
        end
        bad = lut_fark();
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL uniform_lut: %0d differ, lut[%0d] got %0d expected %0d", bad, ilk_fark, lut_obs[ilk_fark], exp_lut[ilk_fark]);
        end
        n_tests++;
        if (hata_at_bitti !== 1'b0 || mesgul_at_bitti !== 1'b0 || mesgul_after_start !== 1'b1) begin
            n_fail++; $display("FAIL uniform_flags: hata=%0b mesgul_end=%0b mesgul_start=%0b expected 0 0 1", hata_at_bitti, mesgul_at_bitti, mesgul_after_start);
        end
        n_tests++;
        if (n_mesgul !== LATENCY || n_wr !== 256 || order_err !== 0 || overlap !== 0) begin
            n_fail++; $display("FAIL uniform_seq: mesgul=%0d writes=%0d order=%0d overlap=%0d expected %0d 256 0 0", n_mesgul, n_wr, order_err, overlap, LATENCY);
        end
    endtask

    task automatic test_two_level();
        int lat, bad;
        logic [255:0] v = '0;
        for (int k = 0; k < 256; k++) begin
            ram[k] = 17'($urandom_range(0, 90000));
            exp_lut[k] = (k < 200) ? 0 : 255;
        end
        ram[10] = 17'd38400; ram[200] = 17'd38400;
        v[10] = 1'b1; v[200] = 1'b1;
        run_pass(v, 17'd38400, -1, lat);
        bad = lut_fark();
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL two_level_lut: %0d differ, lut[%0d] got %0d expected %0d", bad, ilk_fark, lut_obs[ilk_fark], exp_lut[ilk_fark]);
        end
        n_tests++;
        if (hata_at_bitti !== 1'b0 || lat !== LATENCY || n_wr !== 256) begin
            n_fail++; $display("FAIL two_level_done: hata=%0b lat=%0d writes=%0d expected 0 %0d 256", hata_at_bitti, lat, n_wr, LATENCY);
        end
    endtask

    task automatic test_flat();
        int lat, bad;
        logic [255:0] v = '0;
        for (int k = 0; k < 256; k++) begin
            ram[k] = 17'($urandom_range(0, 90000));
            exp_lut[k] = k;
        end
        ram[77] = 17'd76800;
        v[77] = 1'b1;
        run_pass(v, 17'd76800, -1, lat);
        bad = lut_fark();
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL flat_lut: %0d differ, lut[%0d] got %0d expected %0d", bad, ilk_fark, lut_obs[ilk_fark], exp_lut[ilk_fark]);
        end
        n_tests++;
        if (hata_at_bitti !== 1'b0 || lat !== LATENCY) begin
            n_fail++; $display("FAIL flat_done: hata=%0b lat=%0d expected 0 %0d", hata_at_bitti, lat, LATENCY);
        end
    endtask

    task automatic test_valid_gating();
        int lat, bad;
        logic [255:0] v = '0;
        for (int k = 0; k < 256; k++) begin
            ram[k] = 17'd999;
            exp_lut[k] = (k == 255) ? 255 : 0;
        end
        ram[0] = 17'd38400; ram[255] = 17'd38400;
        v[0] = 1'b1; v[255] = 1'b1;
        run_pass(v, 17'd38400, -1, lat);
        n_tests++;
        if (n_rd !== 2) begin
            n_fail++; $display("FAIL gating_reads: got %0d expected 2", n_rd);
        end
        bad = lut_fark();
        n_tests++;
        if (bad !== 0 || hata_at_bitti !== 1'b0) begin
            n_fail++; $display("FAIL gating_lut: %0d differ hata=%0b, lut[%0d] got %0d expected %0d", bad, hata_at_bitti, ilk_fark, lut_obs[ilk_fark], exp_lut[ilk_fark]);
        end
    endtask

    task automatic test_mismatch();
        int lat, bad;
        logic [255:0] v;
        logic [16:0]  cmin;
        make_image(N - 1, v, cmin);
        model(v, int'(cmin));
        run_pass(v, cmin, -1, lat);
        n_tests++;
        if (hata_at_bitti !== 1'b1 || lat !== LATENCY) begin
            n_fail++; $display("FAIL mismatch_hata: hata=%0b lat=%0d expected 1 %0d", hata_at_bitti, lat, LATENCY);
        end
        bad = lut_fark();
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL mismatch_lut: %0d differ, lut[%0d] got %0d expected %0d", bad, ilk_fark, lut_obs[ilk_fark], exp_lut[ilk_fark]);
        end
        repeat (3) @(negedge clk_i);
        n_tests++;
        if (hata_o !== 1'b1) begin
            n_fail++; $display("FAIL mismatch_hold: got %0b expected 1", hata_o);
        end
        make_image(N, v, cmin);
        model(v, int'(cmin));
        run_pass(v, cmin, -1, lat);
        n_tests++;
        if (hata_after_start !== 1'b0 || hata_at_bitti !== 1'b0) begin
            n_fail++; $display("FAIL mismatch_clear: after_start=%0b at_end=%0b expected 0 0", hata_after_start, hata_at_bitti);
        end
    endtask

    task automatic test_control();
        int lat, bad;
        int n = 0;
        logic [255:0] v;
        logic [16:0]  cmin;
        // basla_i pulsed mid-pass must not disturb the running pass
        make_image(N, v, cmin);
        model(v, int'(cmin));
        run_pass(v, cmin, 1000, lat);
        bad = lut_fark();
        n_tests++;
        if (lat !== LATENCY || bad !== 0 || n_wr !== 256 || order_err !== 0) begin
            n_fail++; $display("FAIL control_ignore: lat=%0d lutdiff=%0d writes=%0d order=%0d expected %0d 0 256 0", lat, bad, n_wr, order_err, LATENCY);
        end
        // reset around bin 100 aborts the pass
        make_image(N, v, cmin);
        clear_mon();
        @(negedge clk_i);
        valid_i = v; cdf_min_i = cmin; basla_i = 1'b1;
        @(negedge clk_i);
        basla_i = 1'b0;
        while (n_wr < 100 && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        n_tests++;
        if (mesgul_o !== 1'b0 || n_wr !== 100) begin
            n_fail++; $display("FAIL control_reset: mesgul=%0b writes=%0d expected 0 100", mesgul_o, n_wr);
        end
        repeat (400) @(negedge clk_i);
        n_tests++;
        if (n_wr !== 100 || got_bitti !== 1'b0) begin
            n_fail++; $display("FAIL control_abort: writes=%0d bitti=%0b expected 100 0", n_wr, got_bitti);
        end
        // a fresh start restarts from bin 0
        make_image(N, v, cmin);
        model(v, int'(cmin));
        run_pass(v, cmin, -1, lat);
        bad = lut_fark();
        n_tests++;
        if (lat !== LATENCY || bad !== 0 || n_wr !== 256 || order_err !== 0 || hata_at_bitti !== exp_hata) begin
            n_fail++; $display("FAIL control_restart: lat=%0d lutdiff=%0d writes=%0d order=%0d hata=%0b expected %0d 0 256 0 %0b", lat, bad, n_wr, order_err, hata_at_bitti, LATENCY, exp_hata);
        end
    endtask

    task automatic test_random();
        int lat, bad;
        logic [255:0] v;
        logic [16:0]  cmin;
        make_image(($urandom_range(0, 1) == 0) ? N : N - int'($urandom_range(1, 50)), v, cmin);
        model(v, int'(cmin));
        run_pass(v, cmin, -1, lat);
        bad = lut_fark();
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL random_lut: %0d differ, lut[%0d] got %0d expected %0d", bad, ilk_fark, lut_obs[ilk_fark], exp_lut[ilk_fark]);
        end
        n_tests++;
        if (hata_at_bitti !== exp_hata || lat !== LATENCY || overlap !== 0) begin
            n_fail++; $display("FAIL random_done: hata=%0b lat=%0d overlap=%0d expected %0b %0d 0", hata_at_bitti, lat, overlap, exp_hata, LATENCY);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        basla_i = 1'b0;
        valid_i = '0;
        cdf_min_i = '0;
        clear_mon();
        test_reset();
        test_uniform();
        test_two_level();
        test_flat();
        test_valid_gating();
        test_mismatch();
        test_control();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
